// File: rtl/xsim_msg_framer.sv
// Message framer: takes one indication message (method id + payload words) per
// handshake and streams it out as a header beat followed by the payload beats.
`timescale 1ns/1ps
module xsim_msg_framer #(
  parameter int          MAX_WORDS = 8,
  parameter logic [31:0] PORTAL_ID = 32'd0,
  parameter int          NW_W      = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             in_method,
  input  logic [NW_W-1:0]         in_nwords,
  input  logic [32*MAX_WORDS-1:0] in_payload,
  input  logic                    out_ready,
  output logic                    out_en_beat,
  output logic [31:0]             out_beat,
  output logic [31:0]             out_portal,
  output logic [31:0]             msgs_sent,
  output logic                    err_oversize,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]      method_q;
  logic [NW_W-1:0]  nwords_q;
  logic [31:0]      pay_q [MAX_WORDS];

  logic        accept;
  logic        oversize;
  logic        last_word;
  logic        msg_done;
  logic [15:0] hdr_len;

  // Handshake: an input message transfers on in_valid && in_ready; an output
  // beat transfers on out_en_beat && out_ready. The two never overlap because
  // in_ready is only high in IDLE and out_en_beat only outside IDLE.
  assign in_ready     = (state_q == S_IDLE);
  assign out_en_beat  = (state_q != S_IDLE);
  assign out_portal   = PORTAL_ID;
  assign dbg_state    = state_q;

  assign accept    = in_valid && in_ready;
  assign oversize  = (in_nwords > NW_W'(MAX_WORDS));
  assign last_word = (NW_W'(idx_q) == (nwords_q - NW_W'(1)));
  assign hdr_len   = 16'(nwords_q) + 16'd1;

  assign msg_done = out_ready &&
                    (((state_q == S_HDR) && (nwords_q == '0)) ||
                     ((state_q == S_PAY) && last_word));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    out_beat = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (accept && !oversize) state_d = S_HDR;
      end
      S_HDR: begin
        out_beat = {method_q, hdr_len};
        if (out_ready) begin
          if (nwords_q == '0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAY;
            idx_d   = '0;
          end
        end
      end
      S_PAY: begin
        out_beat = pay_q[idx_q];
        if (out_ready) begin
          if (last_word) state_d = S_IDLE;
          else           idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      method_q     <= '0;
      nwords_q     <= '0;
      msgs_sent    <= 32'd0;
      err_oversize <= 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) pay_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Oversize messages are still consumed so the upstream never stalls on them.
      if (accept) begin
        method_q <= in_method;
        nwords_q <= in_nwords;
        for (int k = 0; k < MAX_WORDS; k++) pay_q[k] <= in_payload[32*k +: 32];
        if (oversize) err_oversize <= 1'b1;
      end
      if (msg_done) msgs_sent <= msgs_sent + 32'd1;
    end
  end

endmodule

// File: tb/tb_xsim_msg_framer.sv
// Directed and table-driven bench for xsim_msg_framer with a beat scoreboard.
`timescale 1ns/1ps
module tb_xsim_msg_framer;

  localparam int MW  = 8;
  localparam int NWW = 8;

  typedef struct packed {
    logic [15:0]     method;
    logic [7:0]      nwords;
    logic [32*MW-1:0] payload;
    logic [31:0]     exp_hdr;
  } vec_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_method = '0;
  logic [NWW-1:0]    in_nwords = '0;
  logic [32*MW-1:0]  in_payload = '0;
  logic              out_ready = 1'b1;
  logic              out_en_beat;
  logic [31:0]       out_beat;
  logic [31:0]       out_portal;
  logic [31:0]       msgs_sent;
  logic              err_oversize;
  logic [1:0]        dbg_state;

  int          total = 0;
  int          bad = 0;
  int          rdy_mode = 0;
  int          exp_msgs = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  vec_t            tbl[5];
  logic [32*MW-1:0] p;
  logic [15:0]     rm;
  logic [7:0]      rn;
  int              ca, cb, base;
  logic [6:0]      pat;

  xsim_msg_framer #(.MAX_WORDS(MW), .PORTAL_ID(32'hCAFE0001), .NW_W(NWW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_method(in_method),
    .in_nwords(in_nwords), .in_payload(in_payload),
    .out_ready(out_ready), .out_en_beat(out_en_beat), .out_beat(out_beat),
    .out_portal(out_portal), .msgs_sent(msgs_sent), .err_oversize(err_oversize),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = driven by the test
  initial forever begin
    @(posedge CLK); #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard / monitor on the falling edge
  logic        prev_stall = 1'b0;
  logic [31:0] prev_beat  = '0;
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      if (prev_stall) begin
        check("stall_en", {31'b0, out_en_beat}, 32'd1);
        check("stall_beat", out_beat, prev_beat);
      end
      check("ready_en_overlap", {31'b0, in_ready && out_en_beat}, 32'd0);
      if (!out_en_beat) check("idle_beat_zero", out_beat, 32'd0);
      if (out_en_beat && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected act=%h exp=none", out_beat);
        end else begin
          check("beat", out_beat, exp_q.pop_front());
        end
      end
    end
    prev_stall = out_en_beat && !out_ready && !RST;
    prev_beat  = out_beat;
  end

  task automatic send_msg(input logic [15:0] m, input logic [7:0] n,
                          input logic [32*MW-1:0] pl, input logic [31:0] hdr);
    int guard = 0;
    while (!in_ready && guard < 500) begin @(posedge CLK); #1; guard++; end
    check("send_ready", {31'b0, in_ready}, 32'd1);
    in_valid   = 1'b1;
    in_method  = m;
    in_nwords  = n;
    in_payload = pl;
    if (n <= MW) begin
      exp_q.push_back(hdr);
      for (int k = 0; k < int'(n); k++) exp_q.push_back(pl[32*k +: 32]);
      exp_msgs++;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 3000) begin
      @(posedge CLK); #1; guard++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_idle", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Stimulus table
    tbl[0].method = 16'h1234; tbl[0].nwords = 8'd8; tbl[0].exp_hdr = 32'h12340009;
    tbl[1].method = 16'hFFFF; tbl[1].nwords = 8'd1; tbl[1].exp_hdr = 32'hFFFF0002;
    tbl[2].method = 16'h0000; tbl[2].nwords = 8'd3; tbl[2].exp_hdr = 32'h00000004;
    tbl[3].method = 16'h8001; tbl[3].nwords = 8'd7; tbl[3].exp_hdr = 32'h80010008;
    tbl[4].method = 16'h00C3; tbl[4].nwords = 8'd0; tbl[4].exp_hdr = 32'h00C30001;
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < MW; k++)
        tbl[i].payload[32*k +: 32] = 32'hA0000000 | (32'(i) << 8) | 32'(k);

    // Reset
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_en", {31'b0, out_en_beat}, 32'd0);
    check("rst_beat", out_beat, 32'd0);
    check("rst_msgs", msgs_sent, 32'd0);
    check("rst_err", {31'b0, err_oversize}, 32'd0);
    check("portal", out_portal, 32'hCAFE0001);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Two-word message, exact cycle timing
    p = '0;
    p[31:0]  = 32'h11111111;
    p[63:32] = 32'h22222222;
    send_msg(16'h0005, 8'd2, p, 32'h00050003);
    check("t1_c1_beat", out_beat, 32'h00050003);
    check("t1_c1_ready", {31'b0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    check("t1_c2_beat", out_beat, 32'h11111111);
    check("t1_c2_ready", {31'b0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    check("t1_c3_beat", out_beat, 32'h22222222);
    check("t1_c3_ready", {31'b0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    check("t1_c4_ready", {31'b0, in_ready}, 32'd1);
    check("t1_c4_en", {31'b0, out_en_beat}, 32'd0);
    check("t1_msgs", msgs_sent, 32'd1);

    // Zero-payload message, then back-to-back accept
    send_msg(16'h00AB, 8'd0, '0, 32'h00AB0001);
    ca = cyc;
    check("t2_hdr", out_beat, 32'h00AB0001);
    check("t2_ready_lo", {31'b0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    check("t2_ready_hi", {31'b0, in_ready}, 32'd1);
    check("t2_msgs", msgs_sent, 32'd2);
    p = '0;
    p[31:0] = 32'h42424242;
    send_msg(16'h0042, 8'd1, p, 32'h00420002);
    cb = cyc;
    check("t2_gap", 32'(cb - ca), 32'd2);
    check("t2_next_hdr", out_beat, 32'h00420002);
    drain();
    check("t2_msgs_end", msgs_sent, 32'd3);

    // Table-driven messages with out_ready held high
    for (int i = 0; i < 5; i++) begin
      send_msg(tbl[i].method, tbl[i].nwords, tbl[i].payload, tbl[i].exp_hdr);
      check("tbl_hdr", out_beat, tbl[i].exp_hdr);
      drain();
      check("tbl_msgs", msgs_sent, 32'(exp_msgs));
    end

    // Back-pressure pattern 1,0,0,1,0,1,1 on a three-word message
    rdy_mode  = 2;
    out_ready = 1'b1;
    p = '0;
    p[31:0]  = 32'h30303030;
    p[63:32] = 32'h31313131;
    p[95:64] = 32'h32323232;
    send_msg(16'h0303, 8'd3, p, 32'h03030004);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      @(posedge CLK); #1;
    end
    check("stall_drained", 32'(exp_q.size()), 32'd0);
    check("stall_idle", {31'b0, in_ready}, 32'd1);
    check("stall_msgs", msgs_sent, 32'(exp_msgs));
    rdy_mode = 0;

    // Oversize messages are dropped
    send_msg(16'hBAD0, 8'd9, '1, 32'd0);
    check("ovs_en", {31'b0, out_en_beat}, 32'd0);
    check("ovs_err", {31'b0, err_oversize}, 32'd1);
    check("ovs_ready", {31'b0, in_ready}, 32'd1);
    check("ovs_msgs", msgs_sent, 32'(exp_msgs));
    send_msg(16'hBAD1, 8'd255, '1, 32'd0);
    @(posedge CLK); #1;
    check("ovs_err_sticky", {31'b0, err_oversize}, 32'd1);
    check("ovs_en2", {31'b0, out_en_beat}, 32'd0);
    send_msg(tbl[2].method, tbl[2].nwords, tbl[2].payload, tbl[2].exp_hdr);
    drain();
    check("ovs_after_msgs", msgs_sent, 32'(exp_msgs));
    check("ovs_err_hold", {31'b0, err_oversize}, 32'd1);

    // Reset in the middle of a five-word message
    for (int k = 0; k < MW; k++) p[32*k +: 32] = 32'h50505050 + 32'(k);
    send_msg(16'h0C0C, 8'd5, p, 32'h0C0C0006);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("mid_beat_w1", out_beat, 32'h50505051);
    rdy_mode  = 2;
    out_ready = 1'b0;
    RST       = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_en", {31'b0, out_en_beat}, 32'd0);
    check("mid_rst_beat", out_beat, 32'd0);
    check("mid_rst_msgs", msgs_sent, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_err", {31'b0, err_oversize}, 32'd0);
    RST = 1'b0;
    exp_q.delete();
    exp_msgs = 0;
    rdy_mode = 0;
    @(posedge CLK); #1;
    p = '0;
    p[31:0]  = 32'hD0D0D0D0;
    p[63:32] = 32'hD1D1D1D1;
    send_msg(16'h0D0D, 8'd2, p, 32'h0D0D0003);
    check("mid_new_hdr", out_beat, 32'h0D0D0003);
    drain();
    check("mid_new_msgs", msgs_sent, 32'd1);

    // Random messages with random back-pressure
    base     = exp_msgs;
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      rn = 8'($urandom_range(0, MW));
      rm = 16'($urandom);
      for (int k = 0; k < MW; k++) p[32*k +: 32] = $urandom;
      send_msg(rm, rn, p, {rm, 16'd0} | (32'(rn) + 32'd1));
    end
    drain();
    check("rand_msgs", msgs_sent, 32'(exp_msgs));
    check("rand_delta", msgs_sent - 32'(base), 32'd1000);
    rdy_mode = 0;

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
